// File: rtl/token_fp_pkg.sv
// Shared types for the token-budget fixed-priority scheduler.
// FSM encoding and grant-index width helper.
package token_fp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/token_fp_scheduler_budget_counter.sv
// Per-queue grant budget: reload on period wrap, decrement on grant.
// Reload dominates decrement; the count saturates at zero.
module budget_counter
    import token_fp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reload_i,
    input  logic             decrement_i,
    input  logic [WIDTH-1:0] reload_value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             zero_q;

    always_comb begin
        count_d = count_q;
        if (reset || reload_i) begin
            count_d = reload_value_i;
        end else if (decrement_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
        zero_q  <= (count_d == '0);
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/token_fp_scheduler.sv
// Fixed-priority scheduler with per-queue grant budgets that are
// replenished every period; one grant per two cycles at most.
module token_fp_scheduler
    import token_fp_pkg::*;
#(
    parameter  int NUMBER_OF_QUEUES = 4,
    parameter  int PRIORITY_SIZE    = 4,
    parameter  int BUDGET_SIZE      = 8,
    parameter  int PERIOD_SIZE      = 16,
    localparam int IW               = id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUMBER_OF_QUEUES*PRIORITY_SIZE-1:0] priorities,
    input  logic [NUMBER_OF_QUEUES*BUDGET_SIZE-1:0] budgets,
    input  logic [PERIOD_SIZE-1:0]                  period,
    input  logic [NUMBER_OF_QUEUES-1:0]             empty,
    input  logic                                    grant_ready,
    output logic                                    grant_valid,
    output logic [IW-1:0]                           grant_id,
    output logic [NUMBER_OF_QUEUES-1:0]             dequeue,
    output logic [NUMBER_OF_QUEUES-1:0]             throttled
);

    localparam int N  = NUMBER_OF_QUEUES;
    localparam int PS = PRIORITY_SIZE;
    localparam int BS = BUDGET_SIZE;

    state_e                 state_q, state_d;
    logic [IW-1:0]          gid_q, gid_d;
    logic [PERIOD_SIZE-1:0] cnt_q, cnt_d;
    logic [PERIOD_SIZE-1:0] period_q;
    logic                   wrap;
    logic                   handshake;
    logic [N-1:0]           zero;
    logic [N-1:0]           eligible;
    logic                   found;
    logic [PS-1:0]          best_pri;
    logic [IW-1:0]          best_id;

    // Period is latched at each wrap so a new value only applies next period.
    assign wrap = (period_q <= PERIOD_SIZE'(1)) ||
                  (cnt_q >= period_q - PERIOD_SIZE'(1));
    assign cnt_d = wrap ? '0 : cnt_q + PERIOD_SIZE'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            period_q <= period;
        end else begin
            cnt_q <= cnt_d;
            if (wrap) begin
                period_q <= period;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_q
        budget_counter #(
            .WIDTH(BS)
        ) u_bc (
            .clock         (clock),
            .reset         (reset),
            .reload_i      (wrap),
            .decrement_i   (handshake && (gid_q == IW'(i))),
            .reload_value_i(budgets[i*BS +: BS]),
            .zero_o        (zero[i])
        );
    end

    assign eligible  = ~empty & ~zero;
    assign throttled = zero;

    // Strict greater-than keeps the lowest index on priority ties.
    always_comb begin
        found    = 1'b0;
        best_pri = '0;
        best_id  = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] &&
                (!found || (priorities[i*PS +: PS] > best_pri))) begin
                found    = 1'b1;
                best_pri = priorities[i*PS +: PS];
                best_id  = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gid_d   = best_id;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready && !reset) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
        end
    end

    assign grant_valid = (state_q == GRANT) && !reset;
    assign grant_id    = gid_q;

    always_comb begin
        dequeue = '0;
        for (int i = 0; i < N; i++) begin
            dequeue[i] = handshake && (gid_q == IW'(i));
        end
    end

endmodule

// File: tb/tb_token_fp_scheduler.sv
// Directed-vector bench for token_fp_scheduler.
// Cycle 1 is the first cycle after reset is released.
module tb_token_fp_scheduler;

    logic        clock;
    logic        reset;
    logic [15:0] priorities;
    logic [31:0] budgets;
    logic [15:0] period;
    logic [3:0]  empty;
    logic        grant_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [3:0]  dequeue;
    logic [3:0]  throttled;

    int tests;
    int failed;
    int cyc;
    int pulses;

    token_fp_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .priorities (priorities),
        .budgets    (budgets),
        .period     (period),
        .empty      (empty),
        .grant_ready(grant_ready),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .dequeue    (dequeue),
        .throttled  (throttled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic begin_test();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 1;
    endtask

    function automatic logic [15:0] prio4(input logic [3:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [31:0] bud4(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    int ids [6] = '{1, 1, 1, 1, 2, 2};

    initial begin
        tests       = 0;
        failed      = 0;
        cyc         = 0;
        reset       = 1'b1;
        grant_ready = 1'b0;
        empty       = 4'hF;
        period      = 16'd1000;
        priorities  = '0;
        budgets     = '0;

        // Highest priority with a tie resolves to index 1.
        priorities  = prio4(4'd3, 4'd9, 4'd9, 4'd1);
        budgets     = bud4(8'd4, 8'd4, 8'd4, 8'd4);
        period      = 16'd1000;
        empty       = 4'b0000;
        grant_ready = 1'b1;
        begin_test();
        @(negedge clock);
        check("rst_valid", grant_valid, 1'b0);
        check("rst_id", grant_id, 2'd0);
        check("rst_deq", dequeue, 4'b0000);
        check("rst_thr", throttled, 4'b0000);
        for (int c = 2; c <= 12; c++) begin
            tick();
            @(negedge clock);
            check("prio_valid", grant_valid, (c % 2 == 0));
            if (c % 2 == 0) check("prio_id", grant_id, ids[c/2-1]);
            if (c == 2) check("prio_deq", dequeue, 4'b0010);
        end

        // Budget 2 per 20-cycle period on queue 2.
        priorities  = prio4(4'd1, 4'd1, 4'd1, 4'd1);
        budgets     = bud4(8'd4, 8'd4, 8'd2, 8'd4);
        period      = 16'd20;
        empty       = 4'b1011;
        grant_ready = 1'b1;
        begin_test();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) tick();
            @(negedge clock);
            check("bud_deq", dequeue,
                  (c == 2 || c == 4 || c == 22 || c == 24) ? 4'b0100 : 4'b0000);
            if (c == 5)  check("bud_thr_on", throttled, 4'b0100);
            if (c == 21) check("bud_thr_off", throttled, 4'b0000);
        end

        // Grant held while not ready even though the queue drains.
        priorities  = prio4(4'd1, 4'd1, 4'd1, 4'd1);
        budgets     = bud4(8'd4, 8'd4, 8'd4, 8'd4);
        period      = 16'd1000;
        empty       = 4'b0111;
        grant_ready = 1'b0;
        begin_test();
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (c == 2) empty = 4'b1111;
            @(negedge clock);
            check("hold_valid", grant_valid, 1'b1);
            check("hold_id", grant_id, 2'd3);
            check("hold_deq", dequeue, 4'b0000);
        end
        tick();
        grant_ready = 1'b1;
        @(negedge clock);
        check("hold_rdy_deq", dequeue, 4'b1000);
        tick();
        @(negedge clock);
        check("hold_after", grant_valid, 1'b0);
        tick();
        @(negedge clock);
        check("hold_idle", grant_valid, 1'b0);

        // Handshake on the wrap cycle: reload must win.
        priorities  = prio4(4'd1, 4'd1, 4'd1, 4'd1);
        budgets     = bud4(8'd3, 8'd4, 8'd4, 8'd4);
        period      = 16'd6;
        empty       = 4'b1110;
        grant_ready = 1'b1;
        begin_test();
        pulses = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            @(negedge clock);
            if (c == 6) check("wrap_deq", dequeue, 4'b0001);
            if (c == 7) check("wrap_thr", throttled, 4'b0000);
            if (c >= 7 && dequeue[0]) pulses++;
        end
        check("wrap_regrants", pulses, 3);

        // Reset in the middle of a grant.
        priorities  = prio4(4'd1, 4'd1, 4'd1, 4'd1);
        budgets     = bud4(8'd0, 8'd2, 8'd4, 8'd0);
        period      = 16'd1000;
        empty       = 4'b1101;
        grant_ready = 1'b0;
        begin_test();
        tick();
        reset       = 1'b1;
        grant_ready = 1'b1;
        @(negedge clock);
        check("mrst_deq_now", dequeue, 4'b0000);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mrst_valid", grant_valid, 1'b0);
        check("mrst_deq", dequeue, 4'b0000);
        check("mrst_thr", throttled, 4'b1001);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clock);
            if (dequeue[1]) pulses++;
        end
        check("mrst_grants", pulses, 2);
        check("mrst_thr_end", throttled, 4'b1011);

        // Zero budget keeps the top-priority queue out.
        priorities  = prio4(4'd15, 4'd2, 4'd7, 4'd7);
        budgets     = bud4(8'd0, 8'd5, 8'd5, 8'd5);
        period      = 16'd1000;
        empty       = 4'b0000;
        grant_ready = 1'b1;
        begin_test();
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) tick();
            @(negedge clock);
            check("zb_deq0", dequeue[0], 1'b0);
            check("zb_thr0", throttled[0], 1'b1);
            if (c == 2)  check("zb_id2", grant_id, 2'd2);
            if (c == 12) check("zb_id3", grant_id, 2'd3);
            if (c == 22) check("zb_id1", grant_id, 2'd1);
        end

        // Period 0 and 1 replenish every cycle; priority 0 is grantable.
        for (int p = 0; p <= 1; p++) begin
            priorities  = prio4(4'd0, 4'd0, 4'd0, 4'd0);
            budgets     = bud4(8'd1, 8'd0, 8'd0, 8'd0);
            period      = 16'(p);
            empty       = 4'b1110;
            grant_ready = 1'b1;
            begin_test();
            pulses = 0;
            for (int c = 1; c <= 10; c++) begin
                if (c > 1) tick();
                @(negedge clock);
                if (dequeue[0]) pulses++;
                if (c == 3) check("p01_thr", throttled, 4'b1110);
            end
            check("p01_grants", pulses, 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
